// File: rtl/fsmc_bridge_mem.sv
// fsmc_bridge_mem: FSMC slave bridging the MCU's asynchronous bus to a
// dual-port on-chip word buffer. The host side has an auto-stepping pointer,
// a command register and a status word. The video side is an independent
// registered read port.
module fsmc_bridge_mem #(
    parameter int DW   = 16,
    parameter int AW   = 10,
    parameter int SYNC = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ncs,
    input  logic          noe,
    input  logic          nwe,
    input  logic          ale,
    input  logic          cle,
    input  logic [DW-1:0] data_i,
    output logic [DW-1:0] data_o,
    output logic          data_oe,
    output logic [AW-1:0] index_o,
    output logic          ovf_o,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    localparam int            DEPTH   = 1 << AW;
    localparam logic [AW-1:0] IDX_MAX = {AW{1'b1}};

    // Synchroniser chain for {ncs, noe, nwe}. Each stage resets to idle (1).
    logic [SYNC-1:0][2:0] sync_reg;
    // Previous synchronised {noe, nwe}, used for edge detection.
    logic [1:0]           strobe_d_reg;
    // Marks when both the synchroniser output and its delayed copy carry real
    // pin samples. Until then, a strobe that was already low before reset
    // release would look like a fresh falling edge.
    logic [SYNC:0]        vld_reg;

    logic                 wr_arm_reg;
    logic [DW-1:0]        wcap_reg;
    logic [AW-1:0]        index_reg;
    logic [1:0]           mode_reg;
    logic                 sat_reg;
    logic                 ovf_reg;
    logic [DW-1:0]        stat_lat_reg;
    logic                 lat_sel_reg;     // 1: host latch shows memory word, 0: status word
    logic [DW-1:0]        mem_q_reg;
    logic [DW-1:0]        rd_data_reg;

    logic [DW-1:0]        mem [DEPTH];

    logic ncs_s, noe_s, nwe_s, noe_d, nwe_d;
    logic sel, sync_ok;
    logic nwe_rise, nwe_fall, noe_fall;
    logic write_ev, read_ev, mem_we, mem_re, stat_re, step_en;
    logic [AW-1:0] step_index;
    logic          step_ovf;
    logic [DW-1:0] status_word;

    assign ncs_s   = sync_reg[SYNC-1][2];
    assign noe_s   = sync_reg[SYNC-1][1];
    assign nwe_s   = sync_reg[SYNC-1][0];
    assign noe_d   = strobe_d_reg[1];
    assign nwe_d   = strobe_d_reg[0];
    assign sel     = ~ncs_s;
    assign sync_ok = vld_reg[SYNC];

    assign nwe_rise = nwe_s & ~nwe_d;
    assign nwe_fall = ~nwe_s & nwe_d;
    assign noe_fall = ~noe_s & noe_d;

    // A write wins over a read in the same cycle; the read is dropped.
    assign write_ev = sel & wr_arm_reg & nwe_rise;
    assign read_ev  = sel & sync_ok & noe_fall & ~write_ev;
    assign mem_we   = write_ev & ~ale & ~cle;
    assign mem_re   = read_ev & ~cle;
    assign stat_re  = read_ev & cle;
    assign step_en  = mem_we | mem_re;

    // Pointer step: an overflow or underflow either wraps the pointer or,
    // in saturate mode, leaves it where it is. Hold modes never flag ovf.
    always_comb begin
        step_index = index_reg;
        step_ovf   = 1'b0;
        case (mode_reg)
            2'b00: begin
                if (index_reg == IDX_MAX) begin
                    step_ovf   = 1'b1;
                    step_index = sat_reg ? index_reg : '0;
                end else begin
                    step_index = index_reg + AW'(1);
                end
            end
            2'b10: begin
                if (index_reg == '0) begin
                    step_ovf   = 1'b1;
                    step_index = sat_reg ? index_reg : IDX_MAX;
                end else begin
                    step_index = index_reg - AW'(1);
                end
            end
            default: ;
        endcase
    end

    // Status word: zero-padded {ovf, sat, mode, index}.
    always_comb begin
        status_word           = '0;
        status_word[AW+3:0]   = {ovf_reg, sat_reg, mode_reg, index_reg};
    end

    // Synchronise the bus strobes and track when the edge detector is trustworthy.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg     <= '1;
            strobe_d_reg <= '1;
            vld_reg      <= '0;
        end else begin
            sync_reg     <= {sync_reg[SYNC-2:0], {ncs, noe, nwe}};
            strobe_d_reg <= {noe_s, nwe_s};
            vld_reg      <= {vld_reg[SYNC-1:0], 1'b1};
        end
    end

    // Host-side control: data capture, write arming, pointer, command and latch select.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_arm_reg   <= 1'b0;
            wcap_reg     <= '0;
            index_reg    <= '0;
            mode_reg     <= 2'b00;
            sat_reg      <= 1'b0;
            ovf_reg      <= 1'b0;
            stat_lat_reg <= '0;
            lat_sel_reg  <= 1'b0;
        end else begin
            // Bus data is taken while the write strobe is low, so the write
            // uses the last stable value and ignores a bus that has moved on.
            if (!nwe_s) begin
                wcap_reg <= data_i;
            end

            if (!sel || write_ev) begin
                wr_arm_reg <= 1'b0;
            end else if (nwe_fall && sync_ok) begin
                wr_arm_reg <= 1'b1;
            end

            if (write_ev && ale) begin
                index_reg <= wcap_reg[AW-1:0];
            end else if (write_ev && cle) begin
                mode_reg <= wcap_reg[1:0];
                sat_reg  <= wcap_reg[2];
                if (wcap_reg[3]) begin
                    ovf_reg <= 1'b0;
                end
            end else if (step_en) begin
                index_reg <= step_index;
                if (step_ovf) begin
                    ovf_reg <= 1'b1;
                end
            end

            if (stat_re) begin
                stat_lat_reg <= status_word;
                lat_sel_reg  <= 1'b0;
            end else if (mem_re) begin
                lat_sel_reg  <= 1'b1;
            end
        end
    end

    // Host memory port: write at the pointer, registered read into the host latch.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[index_reg] <= wcap_reg;
        end
        if (mem_re) begin
            mem_q_reg <= mem[index_reg];
        end
    end

    // Video memory port: registered read every cycle (old data on a same-cycle host write).
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_reg <= '0;
        end else begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign data_o  = lat_sel_reg ? mem_q_reg : stat_lat_reg;
    assign data_oe = ~noe & ~ncs;
    assign index_o = index_reg;
    assign ovf_o   = ovf_reg;
    assign rd_data = rd_data_reg;

endmodule

// File: tb/tb_fsmc_bridge_mem.sv
// tb_fsmc_bridge_mem: drives FSMC-style bus cycles (directed, then random) and
// compares the DUT against a behavioural model of the buffer, pointer and flags.
module tb_fsmc_bridge_mem;

    localparam int DW    = 16;
    localparam int AW    = 10;
    localparam int SYNC  = 3;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          ncs, noe, nwe, ale, cle;
    logic [DW-1:0] data_i;
    logic [DW-1:0] data_o;
    logic          data_oe;
    logic [AW-1:0] index_o;
    logic          ovf_o;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;

    fsmc_bridge_mem #(.DW(DW), .AW(AW), .SYNC(SYNC)) dut (
        .clk     (clk),
        .reset   (reset),
        .ncs     (ncs),
        .noe     (noe),
        .nwe     (nwe),
        .ale     (ale),
        .cle     (cle),
        .data_i  (data_i),
        .data_o  (data_o),
        .data_oe (data_oe),
        .index_o (index_o),
        .ovf_o   (ovf_o),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [DW-1:0] mem_m [DEPTH];
    bit            valid_m [DEPTH];
    int            idx_m;
    logic [1:0]    mode_m;
    bit            sat_m;
    bit            ovf_m;
    logic [DW-1:0] lat_m;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic model_reset();
        idx_m  = 0;
        mode_m = 2'b00;
        sat_m  = 1'b0;
        ovf_m  = 1'b0;
        lat_m  = '0;
    endtask

    // Pointer moves by +1 / -1 / 0; leaving the buffer flags ovf and then
    // either wraps modulo DEPTH or stays put.
    task automatic model_step();
        int delta;
        int nxt;
        delta = (mode_m == 2'b00) ? 1 : (mode_m == 2'b10) ? -1 : 0;
        nxt   = idx_m + delta;
        if (nxt < 0 || nxt >= DEPTH) begin
            ovf_m = 1'b1;
            nxt   = sat_m ? idx_m : (nxt + DEPTH) % DEPTH;
        end
        idx_m = nxt;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_index"}, 32'(index_o), 32'(idx_m));
        check({tag, "_ovf"}, 32'(ovf_o), 32'(ovf_m));
    endtask

    // One host write cycle. With vchk set, the video port watches the written
    // word and must show the old contents on the event cycle, new one after.
    task automatic host_write(input bit a, input bit c, input logic [DW-1:0] d, input bit vchk);
        logic [DW-1:0] old;
        int            widx;
        @(negedge clk);
        ncs = 1'b0; ale = a; cle = c; data_i = d;
        widx = idx_m;
        if (vchk) rd_addr = AW'(widx);
        repeat (2) @(negedge clk);
        nwe = 1'b0;
        repeat (SYNC + 3) @(negedge clk);
        nwe = 1'b1;
        old = mem_m[widx];
        if (vchk) begin
            repeat (SYNC + 1) @(negedge clk);
            check("vid_old", 32'(rd_data), 32'(old));
            @(negedge clk);
            check("vid_new", 32'(rd_data), 32'(d));
            repeat (1) @(negedge clk);
        end else begin
            repeat (SYNC + 3) @(negedge clk);
        end
        ncs = 1'b1; ale = 1'b0; cle = 1'b0; data_i = DW'($urandom);
        @(negedge clk);
        if (a) begin
            idx_m = int'(d[AW-1:0]);
        end else if (c) begin
            mode_m = d[1:0];
            sat_m  = d[2];
            if (d[3]) ovf_m = 1'b0;
        end else begin
            mem_m[idx_m]   = d;
            valid_m[idx_m] = 1'b1;
            model_step();
        end
        $display("write ale=%0b cle=%0b data=%h -> index=%0h ovf=%0b", a, c, d, idx_m, ovf_m);
    endtask

    // One host read cycle; cle selects the status word.
    task automatic host_read(input bit c, input string tag);
        logic [DW-1:0] exp;
        bit            known;
        @(negedge clk);
        ncs = 1'b0; cle = c;
        repeat (2) @(negedge clk);
        noe = 1'b0;
        #1;
        check({tag, "_oe"}, 32'(data_oe), 32'd1);
        repeat (SYNC + 4) @(negedge clk);
        if (c) begin
            exp   = {2'b00, ovf_m, sat_m, mode_m, AW'(idx_m)};
            known = 1'b1;
        end else begin
            exp   = mem_m[idx_m];
            known = valid_m[idx_m];
            model_step();
        end
        lat_m = exp;
        if (known) check({tag, "_data"}, 32'(data_o), 32'(exp));
        noe = 1'b1;
        repeat (SYNC + 3) @(negedge clk);
        ncs = 1'b1; cle = 1'b0;
        @(negedge clk);
        $display("read cle=%0b -> data=%h index=%0h ovf=%0b", c, data_o, idx_m, ovf_m);
    endtask

    task automatic vid_check(input int a, input string tag);
        rd_addr = AW'(a);
        @(negedge clk);
        if (valid_m[a]) check(tag, 32'(rd_data), 32'(mem_m[a]));
    endtask

    // Strobes toggle with chip select high: nothing may change.
    task automatic idle_toggle();
        ncs = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            noe = 1'b0; nwe = 1'b0; cle = k[0]; ale = k[1];
            #1;
            check("idle_oe", 32'(data_oe), 32'd0);
            repeat (SYNC + 2) @(negedge clk);
            noe = 1'b1; nwe = 1'b1;
            repeat (SYNC + 2) @(negedge clk);
        end
        ale = 1'b0; cle = 1'b0;
        check("idle_latch", 32'(data_o), 32'(lat_m));
        $display("idle toggle with ncs high");
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            valid_m[i] = 1'b0;
            mem_m[i]   = '0;
        end
        reset = 1'b1; ncs = 1'b1; noe = 1'b1; nwe = 1'b1;
        ale = 1'b0; cle = 1'b0; data_i = '0; rd_addr = '0;
        repeat (4) @(negedge clk);
        check("rst_data_o", 32'(data_o), 32'd0);
        check("rst_index", 32'(index_o), 32'd0);
        check("rst_ovf", 32'(ovf_o), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_oe", 32'(data_oe), 32'd0);
        reset = 1'b0;
        model_reset();
        repeat (SYNC + 3) @(negedge clk);

        // Pointer wrap at the top of the buffer in +1 / wrap mode
        host_write(1, 0, 16'h0001, 0);
        host_write(0, 0, 16'h1111, 0);
        host_write(1, 0, 16'h03FE, 0);
        host_write(0, 0, 16'hAAAA, 0);
        host_write(0, 0, 16'hBBBB, 0);
        host_write(0, 0, 16'hCCCC, 0);
        check_state("wrap");
        check("wrap_index_const", 32'(index_o), 32'd1);
        vid_check(10'h3FE, "mem_3fe");
        vid_check(10'h3FF, "mem_3ff");
        vid_check(0, "mem_000");

        // Decrement with saturation, then clear ovf
        host_write(0, 1, 16'h0006, 0);
        host_write(1, 0, 16'h0001, 0);
        host_read(0, "dec_rd1");
        host_read(0, "dec_rd2");
        check("dec_last_const", 32'(data_o), 32'hCCCC);
        check_state("dec_sat");
        host_write(0, 1, 16'h0008, 0);
        check_state("ovf_clr");

        // Status read, hold mode
        host_write(0, 1, 16'h0001, 0);
        host_write(1, 0, 16'h0155, 0);
        host_read(1, "status");
        check("status_const", 32'(data_o), 32'h0555);
        check_state("status");

        // Video port read-before-write on the host write cycle
        host_write(0, 1, 16'h0000, 0);
        host_write(1, 0, 16'h0005, 0);
        host_write(0, 0, 16'h5A5A, 0);
        host_write(1, 0, 16'h0005, 0);
        host_write(0, 0, 16'h1234, 1);
        check_state("video");

        // Strobes with chip select high
        idle_toggle();
        check_state("idle");

        // Write strobe held low through reset release must not write
        @(negedge clk);
        reset = 1'b1; ncs = 1'b0; nwe = 1'b0; data_i = 16'hDEAD;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (SYNC + 5) @(negedge clk);
        nwe = 1'b1;
        repeat (SYNC + 5) @(negedge clk);
        ncs = 1'b1;
        @(negedge clk);
        check_state("rst_low_nwe");
        vid_check(0, "rst_low_mem0");
        check("rst_low_data_o", 32'(data_o), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 260; n++) begin
            int            op;
            int            addr;
            logic [DW-1:0] d;
            op = int'($urandom_range(0, 9));
            d  = DW'($urandom);
            case (op)
                0, 1: begin
                    case ($urandom_range(0, 4))
                        0: addr = 0;
                        1: addr = 1;
                        2: addr = DEPTH - 2;
                        3: addr = DEPTH - 1;
                        default: addr = int'($urandom_range(0, DEPTH - 1));
                    endcase
                    d[AW-1:0] = AW'(addr);
                    host_write(1, 0, d, 0);
                end
                2:       host_write(0, 1, d, 0);
                3, 4, 5: host_write(0, 0, d, 0);
                6, 7:    host_read(0, "rnd_rd");
                8:       host_read(1, "rnd_status");
                default: idle_toggle();
            endcase
            check_state("rnd");
            vid_check(int'($urandom_range(0, DEPTH - 1)), "rnd_vid");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
